// File: rtl/uart_rx_oversample.sv
// rtl/uart_rx_oversample.sv - 8N1 UART receiver, 16x oversampling, per-frame baud divisor latch
// Single-byte output holding register with valid/ready handshake and overrun/frame-error pulses.
module uart_rx_oversample #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [16:0] baud,
  input  logic        rx,
  input  logic        rx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        frame_err,
  output logic        overrun,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic [9:0]             div_sel, div_q, tick_cnt;
  logic                   tick, tick_wrap;
  logic [3:0]             os_cnt;
  logic [2:0]             bit_idx;
  logic [7:0]             shift_q;
  logic                   start_det, shift_en, commit, ferr_set;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end
  assign rx_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    div_sel = 10'd326;
    case (baud)
      17'd4800:  div_sel = 10'd651;
      17'd9600:  div_sel = 10'd326;
      17'd14400: div_sel = 10'd217;
      17'd19200: div_sel = 10'd163;
      17'd38400: div_sel = 10'd81;
      17'd57600: div_sel = 10'd54;
      default:   div_sel = 10'd326;
    endcase
  end

  assign tick_wrap = (tick_cnt == div_q - 10'd1);
  assign tick      = (state != IDLE) && tick_wrap;
  assign busy      = (state != IDLE);

  always_comb begin
    state_n   = state;
    start_det = 1'b0;
    shift_en  = 1'b0;
    commit    = 1'b0;
    ferr_set  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n   = START;
          start_det = 1'b1;
        end
      end
      START: begin
        if (tick && os_cnt == 4'd7) state_n = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (tick && os_cnt == 4'd15) begin
          shift_en = 1'b1;
          if (bit_idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (tick && os_cnt == 4'd15) begin
          if (rx_s) begin
            commit  = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_set = 1'b1;
            state_n  = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        // Leave only once the line is high again so a stuck-low line cannot restart a frame.
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= 10'd326;
      tick_cnt <= '0;
      os_cnt   <= '0;
      bit_idx  <= '0;
      shift_q  <= '0;
    end else begin
      if (start_det) div_q <= div_sel;

      if (state == IDLE || tick_wrap) tick_cnt <= '0;
      else                            tick_cnt <= tick_cnt + 10'd1;

      // Every state change restarts the tick phase count; within DATA it wraps every 16 ticks.
      if (state_n != state) os_cnt <= '0;
      else if (tick)        os_cnt <= os_cnt + 4'd1;

      if (state == IDLE)  bit_idx <= '0;
      else if (shift_en)  bit_idx <= bit_idx + 3'd1;

      if (shift_en) shift_q <= {rx_s, shift_q[7:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_set;
      overrun   <= commit && rx_valid && !rx_ready;
      if (commit) begin
        rx_data  <= shift_q;
        rx_valid <= 1'b1;
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// tb/tb_uart_rx_oversample.sv - directed table-driven bench for uart_rx_oversample
module tb_uart_rx_oversample;

  logic        clk = 1'b0;
  logic        rst;
  logic [16:0] baud;
  logic        rx;
  logic        rx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid, frame_err, overrun, busy;

  uart_rx_oversample #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .baud(baud), .rx(rx), .rx_ready(rx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
    .overrun(overrun), .busy(busy)
  );

  always #10 clk = ~clk;

  int         n_chk  = 0;
  int         n_fail = 0;
  int         rises  = 0;
  int         ferrs  = 0;
  int         ovrs   = 0;
  logic       valid_d = 1'b0;
  logic [7:0] seen   = 8'h00;

  always @(negedge clk) begin
    if (rx_valid && !valid_d) rises = rises + 1;
    if (rx_valid) seen = rx_data;
    if (frame_err) ferrs = ferrs + 1;
    if (overrun) ovrs = ovrs + 1;
    valid_d = rx_valid;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic send_frame(input int div, input logic [7:0] b, input logic stop_bit,
                            input logic [16:0] baud_mid);
    rx = 1'b0;
    repeat (2 * div) @(negedge clk);
    baud = baud_mid;
    repeat (14 * div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (16 * div) @(negedge clk);
    end
    rx = stop_bit;
    repeat (16 * div) @(negedge clk);
  endtask

  typedef struct {
    logic [16:0] baud;
    logic [16:0] baud_mid;
    int          div;
    logic [7:0]  data;
    logic        stop_bit;
    logic        ready;
    int          exp_rises;
    logic        exp_level;
    logic [7:0]  exp_seen;
    int          exp_ferr;
    int          exp_ovr;
    logic        exp_busy;
  } vec_t;

  typedef struct {
    logic [16:0] baud;
    int          div;
  } gvec_t;

  vec_t  vecs[4];
  gvec_t gvecs[7];

  initial begin
    int r0, f0, o0, hi;

    vecs[0] = '{17'd57600, 17'd4800,  54, 8'hA5, 1'b1, 1'b1, 1, 1'b0, 8'hA5, 0, 0, 1'b0};
    vecs[1] = '{17'd57600, 17'd57600, 54, 8'h3C, 1'b0, 1'b1, 0, 1'b0, 8'hA5, 1, 0, 1'b1};
    vecs[2] = '{17'd57600, 17'd57600, 54, 8'h11, 1'b1, 1'b0, 1, 1'b1, 8'h11, 0, 0, 1'b0};
    vecs[3] = '{17'd57600, 17'd57600, 54, 8'h22, 1'b1, 1'b0, 0, 1'b1, 8'h22, 0, 1, 1'b0};

    gvecs[0] = '{17'd4800,  651};
    gvecs[1] = '{17'd9600,  326};
    gvecs[2] = '{17'd14400, 217};
    gvecs[3] = '{17'd19200, 163};
    gvecs[4] = '{17'd38400, 81};
    gvecs[5] = '{17'd57600, 54};
    gvecs[6] = '{17'd12345, 326};

    rst = 1'b1; rx = 1'b1; baud = 17'd9600; rx_ready = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_rx_data",   rx_data,   8'h00);
    chk("reset_rx_valid",  rx_valid,  0);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_overrun",   overrun,   0);
    chk("reset_busy",      busy,      0);
    repeat (10) @(negedge clk);

    // Short low pulse: START must run exactly 8 ticks of the selected divisor before rejecting.
    foreach (gvecs[g]) begin
      r0 = rises; f0 = ferrs;
      baud = gvecs[g].baud;
      rx = 1'b0;
      hi = 0;
      for (int t = 0; t < 8 * gvecs[g].div + 200; t++) begin
        @(negedge clk);
        if (t == 19) rx = 1'b1;
        if (busy) hi++;
        else if (hi > 0) break;
      end
      chk($sformatf("glitch_busy_clks_%0d", gvecs[g].baud), hi, 8 * gvecs[g].div);
      chk($sformatf("glitch_no_valid_%0d", gvecs[g].baud), rises - r0, 0);
      chk($sformatf("glitch_no_ferr_%0d", gvecs[g].baud), ferrs - f0, 0);
      repeat (20) @(negedge clk);
    end

    foreach (vecs[v]) begin
      r0 = rises; f0 = ferrs; o0 = ovrs;
      baud = vecs[v].baud;
      rx_ready = vecs[v].ready;
      send_frame(vecs[v].div, vecs[v].data, vecs[v].stop_bit, vecs[v].baud_mid);
      chk($sformatf("v%0d_valid_rises", v), rises - r0, vecs[v].exp_rises);
      chk($sformatf("v%0d_valid_level", v), rx_valid, vecs[v].exp_level);
      chk($sformatf("v%0d_data", v), seen, vecs[v].exp_seen);
      chk($sformatf("v%0d_frame_err", v), ferrs - f0, vecs[v].exp_ferr);
      chk($sformatf("v%0d_overrun", v), ovrs - o0, vecs[v].exp_ovr);
      chk($sformatf("v%0d_busy_end", v), busy, vecs[v].exp_busy);
      rx = 1'b1;
      repeat (64) @(negedge clk);
      chk($sformatf("v%0d_busy_idle", v), busy, 0);
    end

    rx_ready = 1'b1;
    @(negedge clk);
    chk("accept_clears_valid", rx_valid, 0);
    chk("accept_keeps_data", rx_data, 8'h22);

    // Reset in the middle of data bit 4 of 0xFF, then a clean 0x5A frame.
    r0 = rises; f0 = ferrs; o0 = ovrs;
    baud = 17'd57600;
    rx = 1'b0;
    repeat (16 * 54) @(negedge clk);
    rx = 1'b1;
    repeat (4 * 16 * 54 + 8 * 54) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_rx_data", rx_data, 8'h00);
    rst = 1'b0;
    repeat (2000) @(negedge clk);
    chk("rst_abort_no_valid", rises - r0, 0);
    chk("rst_abort_busy", busy, 0);
    send_frame(54, 8'h5A, 1'b1, 17'd57600);
    rx = 1'b1;
    repeat (64) @(negedge clk);
    chk("post_rst_valid_rises", rises - r0, 1);
    chk("post_rst_data", seen, 8'h5A);
    chk("post_rst_frame_err", ferrs - f0, 0);
    chk("post_rst_overrun", ovrs - o0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_oversample.md
UART_RX_OVERSAMPLE -- requirements
Module: uart_rx_oversample

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of flip-flops in the rx input synchronizer (minimum 2).
REQ-002 clk  input  1  system clock, 50 MHz nominal.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 baud  input  17  requested baud rate as an integer value (4800, 9600, 14400, 19200, 38400, 57600).
REQ-005 rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 rx_ready  input  1  consumer accepts rx_data when high together with rx_valid.
REQ-007 rx_data  output  8  received byte.
REQ-008 rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-009 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 overrun  output  1  one-cycle pulse: byte completed while rx_valid was still high.
REQ-011 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 The block SHALL pass rx through SYNC_STAGES flip-flops preset to 1; all logic SHALL use only the synchronized value rx_s.
REQ-013 Divisor lookup (16x oversample, 50 MHz): 4800->651, 9600->326, 14400->217, 19200->163, 38400->81, 57600->54, any other value->326.
REQ-014 The divisor SHALL be latched on start detection and held constant for the whole frame; a baud change mid-frame SHALL affect only the next frame.
REQ-015 The tick counter SHALL count 0..div-1, assert a one-cycle tick at div-1 and wrap to 0; it SHALL be cleared in the cycle of start detection.
REQ-016 FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-017 IDLE->START on the first clk where rx_s=0.
REQ-018 START: after 8 ticks (mid start bit), sample rx_s; 0 -> DATA with bit index 0 and tick count reset; 1 -> IDLE (glitch rejected, no output activity).
REQ-019 DATA: every 16 ticks sample rx_s into the shift register, LSB first; after bit index 7 is sampled -> STOP.
REQ-020 STOP: after 16 ticks sample rx_s; 1 -> commit byte, IDLE; 0 -> frame_err pulse, byte discarded, WAIT_IDLE.
REQ-021 WAIT_IDLE -> IDLE on the first clk where rx_s=1 (a stuck-low line SHALL NOT re-trigger reception).
REQ-022 Commit: rx_data<=shift register and rx_valid<=1 in the same cycle; if rx_valid was already 1 and not being accepted that cycle, rx_data SHALL be overwritten and overrun pulsed.
REQ-023 rx_valid SHALL clear in the cycle after rx_valid&&rx_ready; commit and accept in the same cycle SHALL leave rx_valid=1 with the new byte and no overrun.
REQ-024 rx_data SHALL remain stable while rx_valid=1 and no commit occurs.
REQ-025 Commit latency: rx_valid SHALL rise within 2 clks after the stop-bit sample tick.

Reset
REQ-026 rst SHALL force: FSM IDLE, tick counter 0, bit index 0, shift register 0, synchronizer stages 1, rx_data 8'h00, rx_valid 0, frame_err 0, overrun 0, busy 0, latched divisor 326.
REQ-027 rst asserted mid-frame SHALL abort the frame with no rx_valid, frame_err or overrun activity; after release, the next rx falling edge starts a new frame.

Verification
REQ-028 baud=9600, send 8'hA5 with a valid stop bit, rx_ready=1 -> rx_valid pulses once with rx_data=8'hA5, frame_err=0.
REQ-029 baud=57600, rx low for 20 clks then high -> no rx_valid, FSM back in IDLE within 8 ticks (~432 clks), busy low.
REQ-030 baud=19200, send 8'h3C with stop bit 0 -> frame_err pulses once, rx_valid stays 0, busy stays high until rx returns high.
REQ-031 rx_ready=0, send 8'h11 then 8'h22 at 38400 -> after second frame rx_data=8'h22, rx_valid=1, overrun pulsed once.
REQ-032 baud=4800, assert rst at data bit 4 of 8'hFF, then send 8'h5A -> only 8'h5A is delivered.
REQ-033 baud=12345 (unsupported), send 8'h81 at 9600 timing -> rx_data=8'h81 received correctly.
